mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported synchronous memory between the instruction-fetch port and the data-access port of the pipelined core, so instruction and data storage can live in one unified RAM. A four-state FSM accepts one request at a time, issues a single memory cycle, waits a fixed latency and returns a registered acknowledge. Two-way round-robin arbitration decides simultaneous requests. The fetch and memory stages use the acks as their stall conditions.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from the `mem_en` edge to valid `mem_rdata`; legal range 1..15

Ports:
- `clk`  in  1  single clock, all state on the rising edge
- `reset`  in  1  synchronous, active-high
- `i_req`  in  1  fetch request, held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetched word, valid while `i_ack`=1
- `i_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  read data, valid while `d_ack`=1
- `d_ack`  out  1  one-cycle completion pulse
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  1 whenever state ≠ IDLE

## Operation
FSM states:
- **IDLE**: no access in flight.
  - If any request is high: pick the winner, latch its addr/wdata/we and port id, update `last_grant`, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**: one cycle. `mem_en`=1; `mem_we` = latched we (fetch always 0); `mem_addr`/`mem_wdata` come from the latches. Load `wait_cnt`=MEM_LAT-1. Go to WAIT.
- **WAIT**: stay while `wait_cnt`≠0, decrementing each cycle.
  - When `wait_cnt`=0: capture `mem_rdata` into the granted port's rdata register (reads only) and go to RESP.
  - `wait_cnt` width is $clog2(MEM_LAT+1).
- **RESP**: one cycle. The granted port's ack=1. Go to IDLE.

Arbitration:
- A single requester always wins.
- When both request: the port *not* in `last_grant` wins.
- `last_grant` resets to FETCH, so the first tie goes to data.

Rules:
- All outputs are registered or decoded from state only; no combinational path from req to ack.
- Reset values: state=IDLE, all ack/`mem_en`/`mem_we`/`busy`=0, `mem_addr`/`mem_wdata`/`i_rdata`/`d_rdata`=0, `last_grant`=FETCH.
- On writes, `d_rdata` keeps its previous value. Write ack timing equals read ack timing.
- Addresses pass through unmodified; no alignment check.
- A request dropped before its ack is a protocol violation. The access still completes and the ack still pulses.
- Requests sampled during ISSUE/WAIT/RESP are ignored until IDLE. A requester that still has req high in the cycle after its ack is treated as a new request.
- Reset asserted in any state: next cycle is IDLE with reset values. The in-flight access is abandoned and no ack is issued. A write already strobed in ISSUE is not undone.

## Timing
- Request sampled high in IDLE at edge ending cycle N:
  - `mem_en` high in cycle N+1.
  - WAIT occupies cycles N+2..N+1+MEM_LAT.
  - ack high in cycle N+2+MEM_LAT.
- Request-to-ack latency: MEM_LAT+2 cycles.
- Peak throughput: one access per MEM_LAT+3 cycles (IDLE+ISSUE+WAIT+RESP).
- Both ports requesting continuously are served strictly alternately.
- `busy` rises in the ISSUE cycle and falls in the cycle after RESP.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - port-id constants PORT_I=0, PORT_D=1
  - MEM_LAT legal-range constants
- Sub-module `rr_arb2`: combinational two-way round-robin pick from `i_req`, `d_req` and `last_grant`. Returns grant valid and grant id.
- Everything else (FSM, latches, counter, response registers) lives in the top module.

## Test plan
- Reset, then `i_req`=1, `i_addr`=0x10, RAM[0x10]=0x00500113, MEM_LAT=1 → `mem_en` one cycle after the request, `i_ack`=1 with `i_rdata`=0x00500113 exactly 3 cycles after the request, `busy`=1 for 3 cycles.
- `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF, then a read of 0x40 → `mem_we` pulses once; read ack returns 0xDEADBEEF; `d_rdata` is unchanged during the write ack.
- `i_req`, `d_req` high together after reset, held continuously → grant order D, I, D, I. Each ack arrives MEM_LAT+3 cycles after the previous one.
- MEM_LAT=4, single fetch → ack 6 cycles after the request; `mem_rdata` sampled only at the end of the 4th WAIT cycle (bench drives garbage earlier).
- `reset` asserted during WAIT of a data read → no `d_ack`; state IDLE and all outputs 0 in the next cycle; next `i_req` is served normally.
- `d_req` dropped one cycle after acceptance → access completes, `d_ack` still pulses at N+2+MEM_LAT, no second access issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arbState_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch port, data port and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter view.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Core and memory view.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick between fetch and data requests
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic lastGrant,
  output logic grantValid,
  output logic grantId
);

  // On a tie the port that did not win last time goes next.
  assign grantValid = i_req | d_req;
  assign grantId    = (i_req && d_req) ? ~lastGrant : (d_req ? PORT_D : PORT_I);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported synchronous RAM between fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                       (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam int CNT_W = $clog2(LAT + 1);

  arbState_t         state;
  arbState_t         nextState;
  logic              lastGrant;
  logic              selPort;
  logic              grantValid;
  logic              grantId;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [DATA_W-1:0] iRdata;
  logic [DATA_W-1:0] dRdata;
  logic [CNT_W-1:0]  waitCnt;

  rr_arb2 arb (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .lastGrant  (lastGrant),
    .grantValid (grantValid),
    .grantId    (grantId)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (grantValid) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (waitCnt == '0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= PORT_I;
      selPort   <= PORT_I;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      waitCnt   <= '0;
      iRdata    <= '0;
      dRdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            selPort   <= grantId;
            lastGrant <= grantId;
            if (grantId == PORT_D) begin
              latWe    <= bus.d_we;
              latAddr  <= bus.d_addr;
              latWdata <= bus.d_wdata;
            end else begin
              latWe   <= 1'b0;
              latAddr <= bus.i_addr;
            end
          end
        end
        ISSUE: waitCnt <= CNT_W'(LAT - 1);
        WAIT: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
          end else if (!latWe) begin
            // Only the last WAIT cycle sees valid read data.
            if (selPort == PORT_D) begin
              dRdata <= bus.mem_rdata;
            end else begin
              iRdata <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Everything visible outside is a register or a decode of the state.
  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = (state == ISSUE) && latWe;
  assign bus.mem_addr  = latAddr;
  assign bus.mem_wdata = latWdata;
  assign bus.i_ack     = (state == RESP) && (selPort == PORT_I);
  assign bus.d_ack     = (state == RESP) && (selPort == PORT_D);
  assign bus.i_rdata   = iRdata;
  assign bus.d_rdata   = dRdata;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at MEM_LAT 1 and 4
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;
  logic        iReq, dReq, dWe;
  logic [31:0] iAddr, dAddr, dWdata;
  logic        ldEn;
  logic [7:0]  ldA;
  logic [31:0] ldD;
  int          checks = 0;
  int          errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic        iAck, dAck, memEn, memWe, busy;
  logic [31:0] iRdata, dRdata, memAddr, memWdata, memRdata;
  logic [4:0]  lat;

  assign lat = sel ? 5'd4 : 5'd1;

  assign bus1.i_req = iReq & ~sel;
  assign bus4.i_req = iReq & sel;
  assign bus1.d_req = dReq & ~sel;
  assign bus4.d_req = dReq & sel;
  assign bus1.i_addr = iAddr;
  assign bus4.i_addr = iAddr;
  assign bus1.d_we = dWe;
  assign bus4.d_we = dWe;
  assign bus1.d_addr = dAddr;
  assign bus4.d_addr = dAddr;
  assign bus1.d_wdata = dWdata;
  assign bus4.d_wdata = dWdata;
  assign bus1.mem_rdata = memRdata;
  assign bus4.mem_rdata = memRdata;

  assign iAck     = sel ? bus4.i_ack     : bus1.i_ack;
  assign dAck     = sel ? bus4.d_ack     : bus1.d_ack;
  assign memEn    = sel ? bus4.mem_en    : bus1.mem_en;
  assign memWe    = sel ? bus4.mem_we    : bus1.mem_we;
  assign busy     = sel ? bus4.busy      : bus1.busy;
  assign iRdata   = sel ? bus4.i_rdata   : bus1.i_rdata;
  assign dRdata   = sel ? bus4.d_rdata   : bus1.d_rdata;
  assign memAddr  = sel ? bus4.mem_addr  : bus1.mem_addr;
  assign memWdata = sel ? bus4.mem_wdata : bus1.mem_wdata;

  // RAM model: read data is valid only in the cycle exactly lat edges after the strobe.
  logic [31:0] ram [256];
  logic [31:0] shadow [256];
  logic [31:0] pend = 32'h0;
  logic [31:0] garbage = 32'h0;
  logic [4:0]  age = 5'd0;

  always @(posedge clk) begin
    garbage <= $urandom;
    if (ldEn) ram[ldA] <= ldD;
    if (memEn) begin
      if (memWe) ram[memAddr[7:0]] <= memWdata;
      else pend <= ram[memAddr[7:0]];
      age <= 5'd1;
    end else if (age != 5'd0 && age != 5'd31) begin
      age <= age + 5'd1;
    end
  end

  assign memRdata = (age == lat) ? pend : garbage;

  task automatic chkBit(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, want);
    end
  endtask

  task automatic chkWord(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    iReq  = 1'b0;
    dReq  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ldEn = 1'b1;
      ldA  = i[7:0];
      ldD  = (i == 16) ? 32'h00500113 : (32'hA5000000 | 32'(i));
      shadow[i] = ldD;
    end
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  // One isolated access; watches a fixed window so stray strobes or acks are also seen.
  task automatic access(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] want, input int wantLat,
                        input bit dropEarly, input string tag);
    int ackK, enCnt, weCnt, busyCnt, otherAck;
    ackK = -1; enCnt = 0; weCnt = 0; busyCnt = 0; otherAck = 0;
    @(negedge clk);
    if (port == PORT_D) begin
      dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wdata;
      if (we) shadow[addr[7:0]] = wdata;
    end else begin
      iReq = 1'b1; iAddr = addr;
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (dropEarly && k == 1) dReq = 1'b0;
      enCnt   += int'(memEn);
      weCnt   += int'(memWe);
      busyCnt += int'(busy);
      otherAck += int'(port == PORT_D ? iAck : dAck);
      if (k == 1) begin
        chkWord({tag, " mem_addr"}, memAddr, addr);
        if (we) chkWord({tag, " mem_wdata"}, memWdata, wdata);
      end
      if ((port == PORT_D ? dAck : iAck) && ackK < 0) begin
        ackK = k;
        chkWord({tag, " rdata"}, (port == PORT_D) ? dRdata : iRdata, want);
        iReq = 1'b0;
        dReq = 1'b0;
      end
    end
    chkWord({tag, " latency"}, 32'(ackK), 32'(wantLat));
    chkWord({tag, " mem_en count"}, 32'(enCnt), 32'd1);
    chkWord({tag, " mem_we count"}, 32'(weCnt), {31'b0, we});
    chkWord({tag, " busy cycles"}, 32'(busyCnt), 32'(wantLat));
    chkWord({tag, " other ack"}, 32'(otherAck), 32'd0);
  endtask

  // Transaction-level reference: requesters hold until acked, the arbiter is free
  // again MEM_LAT+3 cycles after a grant, and ties alternate starting with data.
  task automatic randomRun(input int ncyc);
    int          freeAt = 0, issueAt = -100, ackAt = -100, L;
    logic        lastG = PORT_I, ackPort = PORT_I, isWe = 1'b0, win;
    logic [31:0] ackData = 32'h0, isAddr = 32'h0, isWdata = 32'h0, lastDR = 32'h0;
    bit          iPend = 1'b0, dPend = 1'b0;
    L = sel ? 4 : 1;
    doReset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chkBit("rnd i_ack", iAck, (c == ackAt) && (ackPort == PORT_I));
      chkBit("rnd d_ack", dAck, (c == ackAt) && (ackPort == PORT_D));
      chkBit("rnd mem_en", memEn, c == issueAt);
      chkBit("rnd mem_we", memWe, (c == issueAt) && isWe);
      chkBit("rnd busy", busy, (c >= issueAt) && (c <= ackAt));
      if (c == issueAt) begin
        chkWord("rnd mem_addr", memAddr, isAddr);
        if (isWe) chkWord("rnd mem_wdata", memWdata, isWdata);
      end
      if (c == ackAt) begin
        if (ackPort == PORT_D) begin
          chkWord("rnd d_rdata", dRdata, ackData);
          if (!isWe) lastDR = ackData;
          dPend = 1'b0;
        end else begin
          chkWord("rnd i_rdata", iRdata, ackData);
          iPend = 1'b0;
        end
      end
      if (!iPend && ($urandom % 3 == 0)) begin
        iPend = 1'b1;
        iAddr = $urandom;
      end
      if (!dPend && ($urandom % 3 == 0)) begin
        dPend  = 1'b1;
        dWe    = 1'($urandom % 2);
        dAddr  = $urandom;
        dWdata = $urandom;
      end
      iReq = iPend;
      dReq = dPend;
      if (c >= freeAt && (iPend || dPend)) begin
        win     = (iPend && dPend) ? ~lastG : (dPend ? PORT_D : PORT_I);
        lastG   = win;
        ackPort = win;
        issueAt = c + 1;
        ackAt   = c + 2 + L;
        freeAt  = c + 3 + L;
        if (win == PORT_D) begin
          isWe = dWe; isAddr = dAddr; isWdata = dWdata;
          if (dWe) begin
            shadow[dAddr[7:0]] = dWdata;
            ackData = lastDR;
          end else begin
            ackData = shadow[dAddr[7:0]];
          end
        end else begin
          isWe = 1'b0; isAddr = iAddr;
          ackData = shadow[iAddr[7:0]];
        end
      end
    end
    @(negedge clk);
    iReq = 1'b0;
    dReq = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic        sel;
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] want;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prevK, extra;
    reset = 1'b1; sel = 1'b0; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    iAddr = '0; dAddr = '0; dWdata = '0; ldEn = 1'b0; ldA = '0; ldD = '0;

    vecs[0] = '{1'b0, PORT_I, 1'b0, 32'h00000010, 32'h0,        32'h00500113, 3};
    vecs[1] = '{1'b0, PORT_D, 1'b1, 32'h00000040, 32'hDEADBEEF, 32'h00000000, 3};
    vecs[2] = '{1'b0, PORT_D, 1'b0, 32'h00000040, 32'h0,        32'hDEADBEEF, 3};
    vecs[3] = '{1'b0, PORT_I, 1'b0, 32'h00000040, 32'h0,        32'hDEADBEEF, 3};
    vecs[4] = '{1'b0, PORT_D, 1'b1, 32'h00000044, 32'h12345678, 32'hDEADBEEF, 3};
    vecs[5] = '{1'b0, PORT_D, 1'b0, 32'h00000044, 32'h0,        32'h12345678, 3};
    vecs[6] = '{1'b0, PORT_I, 1'b0, 32'hFFFFFF20, 32'h0,        32'hA5000020, 3};
    vecs[7] = '{1'b1, PORT_I, 1'b0, 32'h00000010, 32'h0,        32'h00500113, 6};
    vecs[8] = '{1'b1, PORT_D, 1'b1, 32'h00000080, 32'hCAFEF00D, 32'h00000000, 6};
    vecs[9] = '{1'b1, PORT_D, 1'b0, 32'h00000080, 32'h0,        32'hCAFEF00D, 6};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chkBit("reset i_ack", iAck, 1'b0);
      chkBit("reset d_ack", dAck, 1'b0);
      chkBit("reset mem_en", memEn, 1'b0);
      chkBit("reset mem_we", memWe, 1'b0);
      chkBit("reset busy", busy, 1'b0);
      chkWord("reset i_rdata", iRdata, 32'h0);
      chkWord("reset d_rdata", dRdata, 32'h0);
      chkWord("reset mem_addr", memAddr, 32'h0);
      chkWord("reset mem_wdata", memWdata, 32'h0);
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    preload();

    for (int v = 0; v < 10; v++) begin
      sel = vecs[v].sel;
      access(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].want,
             vecs[v].lat, 1'b0, $sformatf("vec%0d", v));
    end

    // Both ports held high: strict alternation starting with data.
    sel = 1'b0;
    doReset();
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h10; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h20;
    n = 0; prevK = 0; extra = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (iAck || dAck) begin
        if (n < 4) begin
          chkBit($sformatf("tie grant%0d port", n), dAck, (n % 2) == 0);
          chkWord($sformatf("tie grant%0d spacing", n), 32'(k - prevK), (n == 0) ? 32'd3 : 32'd4);
          chkWord($sformatf("tie grant%0d rdata", n), dAck ? dRdata : iRdata,
                  dAck ? 32'hA5000020 : 32'h00500113);
          prevK = k;
          n++;
          if (n == 4) begin
            iReq = 1'b0;
            dReq = 1'b0;
          end
        end else begin
          extra++;
        end
      end
    end
    chkWord("tie ack count", 32'(n), 32'd4);
    chkWord("tie extra acks", 32'(extra), 32'd0);

    // Reset in the middle of a slow data read abandons it.
    sel = 1'b1;
    @(negedge clk);
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h44;
    @(negedge clk);
    @(negedge clk);
    chkBit("abort in wait busy", busy, 1'b1);
    reset = 1'b1;
    dReq  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chkBit("abort busy", busy, 1'b0);
    chkBit("abort d_ack", dAck, 1'b0);
    chkBit("abort i_ack", iAck, 1'b0);
    chkBit("abort mem_en", memEn, 1'b0);
    chkBit("abort mem_we", memWe, 1'b0);
    chkWord("abort mem_addr", memAddr, 32'h0);
    chkWord("abort d_rdata", dRdata, 32'h0);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      extra += int'(dAck) + int'(busy);
    end
    chkWord("abort no late ack", 32'(extra), 32'd0);
    access(PORT_I, 1'b0, 32'h10, 32'h0, 32'h00500113, 6, 1'b0, "after abort");

    // Request dropped right after acceptance still completes once.
    sel = 1'b0;
    access(PORT_D, 1'b0, 32'h20, 32'h0, 32'hA5000020, 3, 1'b1, "dropped req");

    sel = 1'b0;
    randomRun(400);
    sel = 1'b1;
    randomRun(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
